// File: rtl/branch_resolve_buf.sv
// Commit-side buffer of in-flight branches indexed by ROB tag. It collects execution
// results and, at commit, issues a registered redirect/flush and a predictor update.
module branch_resolve_buf #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic [ADDR_W-1:0] alloc_pred_pc,
    input  logic              branch_dest_valid,
    input  logic [TAG_W-1:0]  dest_rob,
    input  logic              taken_rob,
    input  logic [ADDR_W-1:0] branch_dest,
    input  logic              commit_en,
    input  logic [TAG_W-1:0]  commit_tag,
    output logic              commit_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              bp_update_valid,
    output logic [ADDR_W-1:0] bp_update_pc,
    output logic              bp_update_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESOLVED = 2'd2
    } entry_state_t;

    entry_state_t      state_q   [DEPTH];
    entry_state_t      state_d   [DEPTH];
    logic [ADDR_W-1:0] pc_q      [DEPTH];
    logic [ADDR_W-1:0] pred_pc_q [DEPTH];
    logic [ADDR_W-1:0] dest_q    [DEPTH];
    logic              taken_q   [DEPTH];

    logic [DEPTH-1:0]  alloc_hit;
    logic [DEPTH-1:0]  result_hit;
    logic [DEPTH-1:0]  commit_sel;
    logic [ADDR_W-1:0] commit_pc;
    logic [ADDR_W-1:0] commit_pred_pc;
    logic [ADDR_W-1:0] commit_dest;
    logic              commit_taken;
    logic              commit_accept;
    logic              mispredict;

    // Tags are decoded by comparison, so tags >= DEPTH (including the sentinel) match nothing.
    always_comb begin
        alloc_hit  = '0;
        result_hit = '0;
        commit_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_hit[i]  = alloc_en && !flush && (alloc_tag == TAG_W'(i));
            result_hit[i] = branch_dest_valid && !flush && (dest_rob == TAG_W'(i))
                            && (state_q[i] == ST_WAIT);
            commit_sel[i] = (commit_tag == TAG_W'(i));
        end
    end

    always_comb begin
        commit_ready   = 1'b0;
        commit_pc      = '0;
        commit_pred_pc = '0;
        commit_dest    = '0;
        commit_taken   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_sel[i]) begin
                commit_ready   = (state_q[i] == ST_RESOLVED);
                commit_pc      = pc_q[i];
                commit_pred_pc = pred_pc_q[i];
                commit_dest    = dest_q[i];
                commit_taken   = taken_q[i];
            end
        end
    end

    assign commit_accept = commit_en && commit_ready && !flush;
    assign mispredict    = (commit_dest != commit_pred_pc);

    // Allocation outranks a same-tag commit so a recycled tag keeps its fresh data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            if (flush) begin
                state_d[i] = ST_FREE;
            end else if (alloc_hit[i]) begin
                state_d[i] = ST_WAIT;
            end else if (commit_accept && commit_sel[i]) begin
                state_d[i] = ST_FREE;
            end else if (result_hit[i]) begin
                state_d[i] = ST_RESOLVED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]      <= '0;
                pred_pc_q[i] <= '0;
                dest_q[i]    <= '0;
                taken_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_hit[i]) begin
                    pc_q[i]      <= alloc_pc;
                    pred_pc_q[i] <= alloc_pred_pc;
                end
                if (result_hit[i] && !alloc_hit[i]) begin
                    dest_q[i]  <= branch_dest;
                    taken_q[i] <= taken_rob;
                end
            end
        end
    end

    // Commit-side pulses last one cycle; flush is the same registered pulse as redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            bp_update_valid <= 1'b0;
            bp_update_pc    <= '0;
            bp_update_taken <= 1'b0;
            branch_cnt      <= '0;
            mispredict_cnt  <= '0;
        end else begin
            bp_update_valid <= commit_accept;
            redirect_valid  <= commit_accept && mispredict;
            if (commit_accept) begin
                bp_update_pc    <= commit_pc;
                bp_update_taken <= commit_taken;
                branch_cnt      <= branch_cnt + 1'b1;
                if (mispredict) begin
                    redirect_pc    <= commit_dest;
                    mispredict_cnt <= mispredict_cnt + 1'b1;
                end
            end
        end
    end

    assign flush = redirect_valid;

endmodule
